// File: rtl/logic_gate_pipe.sv
// Registered bitwise-logic stage: selected gate of a/b plus AND/OR/XOR reductions of the result, 1-cycle latency.
// Single output register with valid/ready; in_ready drops only while a result is held and not taken.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_and,
  output logic             y_or,
  output logic             y_xor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             op_err,
  output logic [CNT_W-1:0] txn_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             accept;
  logic [WIDTH-1:0] res;
  logic             rsvd;

  // Gating in_ready with rst_n keeps the producer from seeing a ready during reset.
  assign in_ready = rst_n & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign rsvd     = (op_e'(op) == OP_RSVD);

  always_comb begin
    res = '0;
    case (op_e'(op))
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOTA: res = ~a;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      y_and     <= 1'b0;
      y_or      <= 1'b0;
      y_xor     <= 1'b0;
      out_valid <= 1'b0;
      op_err    <= 1'b0;
      txn_count <= '0;
    end else if (accept) begin
      // Reductions are taken from the same value loaded into y so they never lag it.
      y         <= res;
      y_and     <= &res;
      y_or      <= |res;
      y_xor     <= ^res;
      out_valid <= 1'b1;
      if (rsvd) op_err <= 1'b1;
      if (txn_count != CNT_MAX) txn_count <= txn_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized scoreboard bench for logic_gate_pipe, with directed sweeps, backpressure, reserved-op, saturation and async-reset cases.
module tb_logic_gate_pipe;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_valid, out_ready;
  logic       in_ready, y_and, y_or, y_xor, out_valid, op_err;
  logic [7:0] y;
  logic [15:0] txn_count;

  logic       in_ready4, y_and4, y_or4, y_xor4, out_valid4, op_err4;
  logic [7:0] y4;
  logic [3:0] txn_count4;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .y_and(y_and), .y_or(y_or), .y_xor(y_xor),
    .out_valid(out_valid), .out_ready(out_ready), .op_err(op_err), .txn_count(txn_count)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready4), .y(y4), .y_and(y_and4), .y_or(y_or4), .y_xor(y_xor4),
    .out_valid(out_valid4), .out_ready(out_ready), .op_err(op_err4), .txn_count(txn_count4)
  );

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  last_y;
  int          cnt, cnt4;
  logic        err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the gate table applied to whole bytes, reductions on the result.
  function automatic logic [10:0] ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic [2:0] rop);
    logic [7:0] r;
    case (rop)
      3'd0: r = ra & rb;
      3'd1: r = ra | rb;
      3'd2: r = ra ^ rb;
      3'd3: r = ~(ra & rb);
      3'd4: r = ~(ra | rb);
      3'd5: r = ~(ra ^ rb);
      3'd6: r = ~ra;
      default: r = 8'h00;
    endcase
    return {r, &r, |r, ^r};
  endfunction

  task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [2:0] iop, input logic ordy);
    logic [10:0] e;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; op = iop; out_ready = ordy;
    #4;
    if (rst_n && v && (exp_q.size() == 0 || ordy)) begin
      e = ref_model(ia, ib, iop);
      exp_q.push_back(e);
      last_y = e[10:3];
      if (cnt < 65535) cnt++;
      if (cnt4 < 15) cnt4++;
      if (iop == 3'b111) err = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", {y, y_and, y_or, y_xor}, 11'h0);
    chk("rst_flags", {out_valid, op_err, in_ready}, 3'b000);
    chk("rst_cnt", txn_count, 16'h0);
    chk("rst_cnt4", txn_count4, 4'h0);
    exp_q.delete();
    cnt = 0; cnt4 = 0; err = 1'b0; last_y = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_edge_noaccept", {out_valid, txn_count}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);
  endtask

  // Monitor: compares the presented result with the scoreboard head, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("result", {y, y_and, y_or, y_xor}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end else begin
          chk("y_hold", y, last_y);
        end
        chk("op_err", op_err, err);
        chk("txn_count", txn_count, cnt);
        chk("txn_count4", txn_count4, cnt4);
      end
    end
  end

  logic [7:0] sweep_tbl [7];

  initial begin
    sweep_tbl = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C};
    rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 3'd0; out_ready = 1'b0;
    cnt = 0; cnt4 = 0; err = 1'b0; last_y = 8'h00;
    #1;
    chk("init_y", {y, y_and, y_or, y_xor}, 11'h0);
    chk("init_flags", {out_valid, op_err, in_ready, txn_count}, 19'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All ops on C3/A5, streaming.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 8'hC3, 8'hA5, 3'(i), 1'b1);
      @(posedge clk);
      #1;
      chk("sweep_y", y, sweep_tbl[i]);
      chk("sweep_parity", y_xor, ^sweep_tbl[i]);
    end
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("sweep_count", txn_count, 16'd7);

    // Backpressure with a pending producer.
    do_reset();
    step(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h00, 8'hFF, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      chk("bp_y", y, 8'h0F);
      chk("bp_valid_ready", {out_valid, in_ready}, 2'b10);
      chk("bp_count", txn_count, 16'd1);
    end
    step(1'b1, 8'h00, 8'hFF, 3'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_release_y", y, 8'h00);
    chk("bp_release_valid", out_valid, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Reserved op sets a sticky error.
    step(1'b1, 8'hFF, 8'hFF, 3'b111, 1'b1);
    @(posedge clk);
    #1;
    chk("rsvd_y", {y, y_and, y_or, y_xor}, 11'h0);
    chk("rsvd_err", op_err, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i * 37), 8'h5A, 3'(i), 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("rsvd_sticky", op_err, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Counter saturation on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 8'hC3, 3'(i % 7), 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("sat_cnt4", txn_count4, 4'hF);
    chk("sat_cnt16", txn_count, 16'd20);

    // Async reset while a result is held under backpressure.
    step(1'b1, 8'h3C, 8'hF0, 3'd1, 1'b1);
    step(1'b1, 8'h11, 8'h22, 3'd0, 1'b0);
    step(1'b1, 8'h11, 8'h22, 3'd0, 1'b0);
    do_reset();
    step(1'b1, 8'hC3, 8'hA5, 3'd2, 1'b1);
    @(posedge clk);
    #1;
    chk("post_rst_y", y, 8'h66);
    chk("post_rst_cnt", txn_count, 16'd1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
